// File: rtl/zero_cross_edge.sv
// zero_cross_edge: raster scan of a 3x3 signed Laplacian window per pixel with thresholded
// zero-crossing classification, streamed out through a credit-managed FWFT FIFO.

module zc_pair #(
  parameter int PXL_BITS = 12
) (
  input  logic [PXL_BITS-1:0] i_a,
  input  logic [PXL_BITS-1:0] i_b,
  input  logic [PXL_BITS-1:0] i_thresh,
  output logic                o_hit
);
  logic signed [PXL_BITS:0] w_a, w_b, w_d;
  logic        [PXL_BITS:0] w_mag;
  logic w_an, w_ap, w_bn, w_bp, w_cross;

  // One extra bit keeps |a-b| exact across the full signed range.
  assign w_a   = {i_a[PXL_BITS-1], i_a};
  assign w_b   = {i_b[PXL_BITS-1], i_b};
  assign w_d   = w_a - w_b;
  assign w_mag = w_d[PXL_BITS] ? -w_d : w_d;

  assign w_an    = i_a[PXL_BITS-1];
  assign w_ap    = !i_a[PXL_BITS-1] && (|i_a);
  assign w_bn    = i_b[PXL_BITS-1];
  assign w_bp    = !i_b[PXL_BITS-1] && (|i_b);
  assign w_cross = (w_an && w_bp) || (w_ap && w_bn);
  assign o_hit   = w_cross && (w_mag >= {1'b0, i_thresh});
endmodule

module zero_cross_edge #(
  parameter int IMG_WD     = 8,
  parameter int IMG_HT     = 8,
  parameter int COORD_BITS = 3,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [PXL_BITS-1:0]                 thresh,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [COORD_BITS-1:0]               rd_x,
  output logic [COORD_BITS-1:0]               rd_y,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]   rd_data_flat,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_edge,
  output logic [COORD_BITS-1:0]               out_x,
  output logic [COORD_BITS-1:0]               out_y,
  output logic                                out_last
);
  localparam int NPAIR = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic                  edg;
    logic [COORD_BITS-1:0] x;
    logic [COORD_BITS-1:0] y;
    logic                  last;
  } beat_t;

  state_t                r_state, w_state_nxt;
  logic [PXL_BITS-1:0]   r_thresh;
  logic [COORD_BITS-1:0] r_cur_x, r_cur_y;
  logic                  r_rd_pend;
  logic [COORD_BITS-1:0] r_rd_x, r_rd_y;
  logic                  r_rd_last;
  logic                  w_cur_last, w_credit_ok;

  beat_t                 r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr, r_rd;
  logic [CNT_W-1:0]      r_cnt;
  beat_t                 w_push_beat, w_head;
  logic                  w_push, w_pop;

  logic [NPAIR-1:0][PXL_BITS-1:0] w_pa, w_pb;
  logic [NPAIR-1:0]               w_hit;
  logic                           w_unused_ctr;

  // Opposing pairs around the centre: horizontal, vertical, main and anti diagonal.
  assign w_pa[0] = rd_data_flat[(1*WIN_WD+0)*PXL_BITS +: PXL_BITS];
  assign w_pb[0] = rd_data_flat[(1*WIN_WD+2)*PXL_BITS +: PXL_BITS];
  assign w_pa[1] = rd_data_flat[(0*WIN_WD+1)*PXL_BITS +: PXL_BITS];
  assign w_pb[1] = rd_data_flat[(2*WIN_WD+1)*PXL_BITS +: PXL_BITS];
  assign w_pa[2] = rd_data_flat[(0*WIN_WD+0)*PXL_BITS +: PXL_BITS];
  assign w_pb[2] = rd_data_flat[(2*WIN_WD+2)*PXL_BITS +: PXL_BITS];
  assign w_pa[3] = rd_data_flat[(0*WIN_WD+2)*PXL_BITS +: PXL_BITS];
  assign w_pb[3] = rd_data_flat[(2*WIN_WD+0)*PXL_BITS +: PXL_BITS];
  assign w_unused_ctr = ^rd_data_flat[(1*WIN_WD+1)*PXL_BITS +: PXL_BITS];

  for (genvar i = 0; i < NPAIR; i++) begin : g_pair
    zc_pair #(.PXL_BITS(PXL_BITS)) u_pair (
      .i_a(w_pa[i]), .i_b(w_pb[i]), .i_thresh(r_thresh), .o_hit(w_hit[i])
    );
  end

  // Credits cover both queued beats and the read whose data lands this cycle.
  assign w_credit_ok = ({1'b0, r_cnt} + (CNT_W+1)'(r_rd_pend)) < (CNT_W+1)'(FIFO_DEPTH);
  assign w_cur_last  = (r_cur_x == X_LAST) && (r_cur_y == Y_LAST);
  assign rd_x        = r_cur_x;
  assign rd_y        = r_cur_y;

  assign w_push      = r_rd_pend;
  assign w_push_beat = {|w_hit, r_rd_x, r_rd_y, r_rd_last};
  assign w_head      = r_mem[r_rd];
  assign out_valid   = (r_cnt != '0);
  assign w_pop       = out_valid && out_ready;
  assign out_edge    = out_valid && w_head.edg;
  assign out_x       = out_valid ? w_head.x : '0;
  assign out_y       = out_valid ? w_head.y : '0;
  assign out_last    = out_valid && w_head.last;

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN: begin
        busy  = 1'b1;
        rd_en = w_credit_ok;
        if (w_credit_ok && w_cur_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_head.last && !r_rd_pend) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_thresh  <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_rd_pend <= 1'b0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= rd_en;
      if (r_state == S_IDLE && start) begin
        r_thresh <= thresh;
        r_cur_x  <= '0;
        r_cur_y  <= '0;
      end
      if (rd_en) begin
        r_rd_x    <= r_cur_x;
        r_rd_y    <= r_cur_y;
        r_rd_last <= w_cur_last;
        if (r_cur_x == X_LAST) begin
          r_cur_x <= '0;
          r_cur_y <= (r_cur_y == Y_LAST) ? '0 : r_cur_y + COORD_BITS'(1);
        end else begin
          r_cur_x <= r_cur_x + COORD_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_cnt == CNT_W'(FIFO_DEPTH)));
endmodule

// File: doc/zero_cross_edge.md
Name: zero_cross_edge

Overview:
Stage directly downstream of the intensity gradient kernel. It scans the destination gradient frame buffer in raster order and reads a 3x3 window of signed Laplacian values per pixel. It classifies the centre pixel as edge/non-edge by thresholded zero-crossing detection. Results leave as a 1-bit raster stream with valid/ready backpressure, buffered by a small credit-managed FIFO, toward the edge-map sink.

Parameters:
IMG_WD, 8, image width in pixels
IMG_HT, 8, image height in pixels
COORD_BITS, 3, bits to address any X or Y coordinate
WIN_WD, 3, window width; must be 3
WIN_HT, 3, window height; must be 3
PXL_BITS, 12, signed gradient value width
FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame scan when idle
thresh  in  PXL_BITS  unsigned zero-crossing threshold, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the frame is fully emitted
rd_en  out  1  gradient buffer read request
rd_x  out  COORD_BITS  read window centre X
rd_y  out  COORD_BITS  read window centre Y
rd_data_flat  in  WIN_HT*WIN_WD*PXL_BITS  window, row-major, [y][x] at bit offset (y*WIN_WD+x)*PXL_BITS; valid exactly 1 cycle after rd_en
out_valid  out  1  output beat valid
out_ready  in  1  sink accepts beat
out_edge  out  1  1 = edge pixel
out_x  out  COORD_BITS  pixel X
out_y  out  COORD_BITS  pixel Y
out_last  out  1  marks pixel (IMG_WD-1, IMG_HT-1)

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_x=rd_y=0, out_valid=0, out_edge=out_x=out_y=out_last=0. FSM=IDLE, FIFO empty, in-flight count 0.
- FSM states are IDLE, SCAN, DRAIN, DONE.
- IDLE: on start=1, latch thresh, set cur=(0,0), go to SCAN. start is ignored in all other states.
- SCAN: rd_en=1 when fifo_count + inflight < FIFO_DEPTH; otherwise rd_en=0 and the coordinate holds. Each issued read advances X; at X=IMG_WD-1 it wraps to 0 and increments Y. Issuing (IMG_WD-1, IMG_HT-1) moves the FSM to DRAIN.
- Read data return: the cycle after rd_en, rd_data_flat is classified combinationally and pushed with the registered coordinate into the FIFO at the end of that cycle.
- Classification: pairs are (w[1][0],w[1][2]), (w[0][1],w[2][1]), (w[0][0],w[2][2]), (w[0][2],w[2][0]). A pair crosses when one value is <0 and the other is >0; zero does not count as a sign. For a crossing pair, diff = |a-b| is computed in PXL_BITS+1 bits with no overflow. edge=1 if any crossing pair has diff >= latched thresh. The centre value is unused.
- Latency: rd_en in cycle N gives the earliest out_valid in cycle N+2. With out_ready held 1, throughput is 1 pixel/cycle.
- FIFO: first-word-fall-through; out_* are driven from the head entry. A beat transfers when out_valid & out_ready. Simultaneous push and pop are legal at any occupancy. The credit rule makes overflow impossible, and a push while full is a design error (assertion).
- DRAIN: no reads are issued. The FSM goes to DONE when inflight=0, the FIFO is empty, and the out_last beat has transferred.
- DONE: done=1 for one cycle with busy=0, then the FSM returns to IDLE.
- Beats are emitted in strict raster order, exactly IMG_WD*IMG_HT per frame.
- out_last=1 only on the final pixel.
- Border window content is the frame buffer's responsibility and is used as supplied.
- A thresh change during a frame has no effect.
- Reset mid-frame: everything returns to reset values immediately. FIFO contents and in-flight read data are discarded, and no done pulse is produced.

Test Plan:
- All-zero frame, thresh=1, out_ready=1 -> 64 beats in raster order, all edge=0; out_last only on (7,7); done pulses the cycle after the FSM sees the last transfer.
- Window with w[1][0]=-5, w[1][2]=+5, others 0, thresh=10 -> edge=1; thresh=11 -> edge=0; w[1][0]=0, w[1][2]=+5 -> edge=0 (zero is no crossing).
- Diagonal pair w[0][0]=-2048, w[2][2]=+2047, thresh=4095 -> edge=1; diff=4095 computed without wrap.
- out_ready low for 20 cycles mid-scan -> at most FIFO_DEPTH beats outstanding, rd_en deasserts, and scan resumes with no loss, duplication or reorder.
- start pulsed while busy, and thresh changed mid-frame -> no effect on the scan, beat count or classification.
- rst_n asserted mid-frame with FIFO non-empty -> out_valid=0 and busy=0 immediately, no done; a new start scans from (0,0) correctly.
